// File: rtl/synapse_event_dispatcher.sv
// Synaptic event dispatcher: queues presynaptic spikes, walks every target of the
// popped source through a weight table and emits one event per nonzero weight.
module synapse_event_dispatcher #(
  parameter int SRC_WIDTH    = 6,
  parameter int TGT_WIDTH    = 3,
  parameter int WEIGHT_WIDTH = 8,
  parameter int FIFO_DEPTH   = 8,
  parameter int SKIP_ZERO    = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              enable,
  input  logic                              spk_in_valid,
  output logic                              spk_in_ready,
  input  logic [SRC_WIDTH-1:0]              spk_in_src,
  input  logic                              cfg_we,
  input  logic [SRC_WIDTH+TGT_WIDTH-1:0]    cfg_addr,
  input  logic [WEIGHT_WIDTH:0]             cfg_wdata,
  output logic                              syn_valid,
  input  logic                              syn_ready,
  output logic [TGT_WIDTH-1:0]              syn_target,
  output logic [WEIGHT_WIDTH-1:0]           syn_weight,
  output logic                              syn_excitatory,
  output logic                              busy,
  output logic [$clog2(FIFO_DEPTH):0]       fifo_count,
  output logic [31:0]                       events_out
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int ADDR_W = SRC_WIDTH + TGT_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EMIT} state_t;

  state_t                 state, state_nxt;
  logic [SRC_WIDTH-1:0]   fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [CNT_W-1:0]       count;
  logic                   fifo_full, fifo_empty, push, pop;

  logic [WEIGHT_WIDTH:0]  wtab [1 << ADDR_W];
  logic [WEIGHT_WIDTH:0]  rd_data;
  logic [SRC_WIDTH-1:0]   cur_src;
  logic [TGT_WIDTH-1:0]   cur_tgt;
  logic                   handshake, out_free, is_skip, load_out, advance;

  assign fifo_full    = (count == CNT_W'(FIFO_DEPTH));
  assign fifo_empty   = (count == '0);
  // Ready depends only on occupancy, so a full FIFO refuses even when popping.
  assign spk_in_ready = !fifo_full;
  assign push         = spk_in_valid && !fifo_full;
  assign pop          = (state == S_IDLE) && enable && !fifo_empty;
  assign fifo_count   = count;
  assign busy         = (state != S_IDLE) || !fifo_empty;

  assign handshake = syn_valid && syn_ready;
  assign out_free  = !syn_valid || syn_ready;
  assign is_skip   = (SKIP_ZERO != 0) && (rd_data[WEIGHT_WIDTH-1:0] == '0);

  // NOTE: storage arrays carry no reset so they map onto plain RAM; only control state is reset.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= spk_in_src;
  end

  // NOTE: sequential state always uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Read-first table: a write and a read to one address in the same cycle return old data.
  always_ff @(posedge clk) begin
    if (cfg_we)             wtab[cfg_addr] <= cfg_wdata;
    if (state == S_READ)    rd_data        <= wtab[{cur_src, cur_tgt}];
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    load_out  = 1'b0;
    advance   = 1'b0;
    case (state)
      S_IDLE: if (pop) state_nxt = S_READ;
      S_READ: state_nxt = S_EMIT;
      S_EMIT: begin
        if (is_skip) begin
          advance = 1'b1;
        end else if (out_free) begin
          load_out = 1'b1;
          advance  = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (advance) state_nxt = (cur_tgt == '1) ? S_IDLE : S_READ;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cur_src <= '0;
      cur_tgt <= '0;
    end else begin
      state <= state_nxt;
      if (pop) begin
        cur_src <= fifo_mem[rd_ptr];
        cur_tgt <= '0;
      end else if (advance) begin
        cur_tgt <= cur_tgt + 1'b1;
      end
    end
  end

  // The output register holds an event until accepted; the next target's read overlaps it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      syn_valid      <= 1'b0;
      syn_target     <= '0;
      syn_weight     <= '0;
      syn_excitatory <= 1'b0;
    end else if (load_out) begin
      syn_valid      <= 1'b1;
      syn_target     <= cur_tgt;
      syn_weight     <= rd_data[WEIGHT_WIDTH-1:0];
      syn_excitatory <= !rd_data[WEIGHT_WIDTH];
    end else if (handshake) begin
      syn_valid      <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                              events_out <= '0;
    else if (handshake && events_out != '1)  events_out <= events_out + 32'd1;
  end

endmodule

// File: tb/tb_synapse_event_dispatcher.sv
// Randomized and directed bench for synapse_event_dispatcher against a
// scoreboard built from a shadow weight table and the per-source fan-out rule.
module tb_synapse_event_dispatcher;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        spk_in_valid;
  logic        spk_in_ready;
  logic [5:0]  spk_in_src;
  logic        cfg_we;
  logic [8:0]  cfg_addr;
  logic [8:0]  cfg_wdata;
  logic        syn_valid;
  logic        syn_ready;
  logic [2:0]  syn_target;
  logic [7:0]  syn_weight;
  logic        syn_excitatory;
  logic        busy;
  logic [3:0]  fifo_count;
  logic [31:0] events_out;

  always #5 clk = ~clk;

  synapse_event_dispatcher dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .spk_in_valid(spk_in_valid), .spk_in_ready(spk_in_ready), .spk_in_src(spk_in_src),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .syn_valid(syn_valid), .syn_ready(syn_ready), .syn_target(syn_target),
    .syn_weight(syn_weight), .syn_excitatory(syn_excitatory),
    .busy(busy), .fifo_count(fifo_count), .events_out(events_out)
  );

  typedef struct packed {
    logic [2:0] tgt;
    logic [7:0] w;
    logic       exc;
  } ev_t;

  logic [8:0] tbl [512];
  ev_t        exp_q [$];
  int         total_exp = 0;
  int         n_vec = 0;
  int         n_err = 0;
  logic       prev_stall = 1'b0;
  logic [11:0] prev_fields = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected fan-out of one source: every target in order whose magnitude is nonzero.
  function automatic void enqueue(input logic [5:0] src);
    for (int t = 0; t < 8; t++) begin
      logic [8:0] w;
      ev_t e;
      w = tbl[{src, 3'(t)}];
      if (w[7:0] != 8'h00) begin
        e.tgt = 3'(t);
        e.w   = w[7:0];
        e.exc = !w[8];
        exp_q.push_back(e);
        total_exp++;
      end
    end
  endfunction

  // Pre-edge monitor: sees exactly the values the next rising edge will act on.
  always begin
    @(negedge clk);
    #4;
    if (!rst_n) begin
      exp_q.delete();
      total_exp  = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 64'(syn_valid), 64'(1));
        check("hold_fields", 64'({syn_target, syn_weight, syn_excitatory}), 64'(prev_fields));
      end
      if (syn_valid && syn_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", 64'({syn_target, syn_weight, syn_excitatory}), 64'hdead);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          check("event", 64'({syn_target, syn_weight, syn_excitatory}), 64'(e));
        end
      end
      prev_stall  = syn_valid && !syn_ready;
      prev_fields = {syn_target, syn_weight, syn_excitatory};
      if (spk_in_valid && spk_in_ready) enqueue(spk_in_src);
    end
  end

  task automatic cfg_write(input logic [8:0] addr, input logic [8:0] data);
    @(negedge clk);
    cfg_we    = 1'b1;
    cfg_addr  = addr;
    cfg_wdata = data;
    tbl[addr] = data;
  endtask

  task automatic cfg_idle();
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Returns just after the edge that accepts the push.
  task automatic push(input logic [5:0] src);
    @(negedge clk);
    spk_in_valid = 1'b1;
    spk_in_src   = src;
    @(negedge clk);
    spk_in_valid = 1'b0;
  endtask

  task automatic wait_quiet(input int max_cyc, input string tag);
    int c;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while ((busy || syn_valid) && c < max_cyc);
    check(tag, 64'(busy || syn_valid), 64'(0));
    check({tag, "_queue_empty"}, 64'(exp_q.size()), 64'(0));
    check({tag, "_events_out"}, 64'(events_out), 64'(total_exp));
  endtask

  initial begin
    int first_v, first_idle;
    logic [31:0] ev0;
    logic seen;

    rst_n = 1'b0; enable = 1'b1; spk_in_valid = 1'b0; spk_in_src = '0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; syn_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_syn_valid", 64'(syn_valid), 64'(0));
    check("rst_fifo_count", 64'(fifo_count), 64'(0));
    check("rst_events_out", 64'(events_out), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_ready", 64'(spk_in_ready), 64'(1));
    check("rst_syn_fields", 64'({syn_target, syn_weight, syn_excitatory}), 64'(0));
    rst_n = 1'b1;

    // Whole table with a mix of zero, inhibitory and excitatory weights.
    for (int a = 0; a < 512; a++)
      cfg_write(9'(a), {1'($urandom_range(0, 3) == 0),
                        ($urandom_range(0, 9) < 3) ? 8'h00 : 8'($urandom_range(1, 255))});
    for (int t = 0; t < 8; t++) cfg_write({6'd5, 3'(t)}, {t == 1, 8'(t + 1)});
    for (int t = 0; t < 8; t++)
      cfg_write({6'd2, 3'(t)}, (t == 3) ? 9'h040 : (t == 6) ? 9'h010 : 9'h000);
    for (int t = 0; t < 8; t++) cfg_write({6'd9, 3'(t)}, {1'b0, 8'(8'h20 + t)});
    cfg_idle();

    // Single source: latency, inhibitory target, 17-cycle fan-out.
    push(6'd5);
    first_v = -1; first_idle = -1; seen = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (first_v < 0 && syn_valid) first_v = c;
      if (first_idle < 0 && !busy) first_idle = c;
      if (syn_valid && syn_target == 3'd1 && !seen) begin
        check("tgt1_inhibit", 64'(syn_excitatory), 64'(0));
        seen = 1'b1;
      end
    end
    check("first_valid_cycle", 64'(first_v), 64'(3));
    check("busy_drop_cycle", 64'(first_idle), 64'(17));
    check("single_events_out", 64'(events_out), 64'(8));
    check("single_queue_empty", 64'(exp_q.size()), 64'(0));

    // Zero skip: only two nonzero weights for source 2.
    ev0 = events_out;
    push(6'd2);
    wait_quiet(60, "zero_skip_quiet");
    check("zero_skip_delta", 64'(events_out - ev0), 64'(2));

    // Backpressure on the first event.
    syn_ready = 1'b0;
    push(6'd5);
    first_v = 0;
    while (!syn_valid && first_v < 20) begin
      @(negedge clk);
      first_v++;
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_valid", 64'(syn_valid), 64'(1));
      check("bp_fields", 64'({syn_target, syn_weight}), 64'({3'd0, 8'd1}));
    end
    syn_ready = 1'b1;
    wait_quiet(80, "bp_quiet");

    // FIFO full with dispatch disabled, then in-order drain.
    enable = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check("fill_ready", 64'(spk_in_ready), 64'(i < 8));
      spk_in_valid = 1'b1;
      spk_in_src   = 6'(10 + i);
    end
    @(negedge clk);
    spk_in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("full_count", 64'(fifo_count), 64'(8));
    check("full_no_emit", 64'(syn_valid), 64'(0));
    check("full_busy", 64'(busy), 64'(1));
    enable = 1'b1;
    wait_quiet(400, "drain_quiet");

    // Collision: rewrite target 4 in the very cycle it is read.
    push(6'd9);
    seen = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == 9) begin
        cfg_we = 1'b1; cfg_addr = {6'd9, 3'd4}; cfg_wdata = 9'h0a5; tbl[{6'd9, 3'd4}] = 9'h0a5;
      end else begin
        cfg_we = 1'b0;
      end
      if (syn_valid && syn_target == 3'd4 && !seen) begin
        check("collision_old", 64'(syn_weight), 64'(8'h24));
        seen = 1'b1;
      end
    end
    check("collision_seen", 64'(seen), 64'(1));
    push(6'd9);
    seen = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (syn_valid && syn_target == 3'd4 && !seen) begin
        check("collision_new", 64'(syn_weight), 64'(8'ha5));
        seen = 1'b1;
      end
    end
    wait_quiet(40, "collision_quiet");

    // Reset in the middle of a fan-out with more sources queued.
    push(6'd5);
    push(6'd6);
    push(6'd7);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_syn_valid", 64'(syn_valid), 64'(0));
    check("midrst_fifo_count", 64'(fifo_count), 64'(0));
    check("midrst_events_out", 64'(events_out), 64'(0));
    check("midrst_ready", 64'(spk_in_ready), 64'(1));
    check("midrst_busy", 64'(busy), 64'(0));
    rst_n = 1'b1;

    // Random traffic, backpressure and enable toggling.
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      spk_in_valid = ($urandom_range(0, 3) == 0);
      spk_in_src   = 6'($urandom_range(0, 63));
      syn_ready    = ($urandom_range(0, 9) < 7);
      enable       = ($urandom_range(0, 9) < 8);
    end
    @(negedge clk);
    spk_in_valid = 1'b0;
    enable       = 1'b1;
    syn_ready    = 1'b1;
    wait_quiet(3000, "random_quiet");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
